mem_port_arbiter: RTL

- Sequences a single-port unified memory between two requesters of the RV32 core: instruction fetch (PC side) and data load/store (ALUResult/WriteData side).
- Grants one request at a time and holds the owner's handshake until the memory acknowledges.
- Produces a stall so the PC register and register-file write hold while either access is outstanding.
- Includes a starvation limit for fetch and a watchdog timeout so the core never hangs.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/arb_watchdog.sv | 37 +++
 rtl/mem_port_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: FSM encoding, owner
// tag and the full-word byte-enable constant.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_WAIT = 2'd1,
    D_WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  localparam logic [3:0] BE_FULL = 4'hF;

endpackage

// File: rtl/arb_watchdog.sv
// Wait-state cycle counter for the arbiter; flags expiry on the last
// allowed cycle. TIMEOUT = 0 disables expiry entirely.
module arb_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (TIMEOUT != 0) && (cnt_q == CW'(LAST));

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access,
// with fetch starvation limit, watchdog abort and pipeline stall output.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW              = 32,
  parameter int DW              = 32,
  parameter int MAX_DATA_GRANTS = 4,
  parameter int TIMEOUT         = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  output logic          if_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_be,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic          d_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall
);

  localparam logic [3:0] MAX_G = 4'(MAX_DATA_GRANTS);

  arb_state_t    state_q, state_d;
  logic [3:0]    starve_q, starve_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;

  logic   in_wait;
  logic   expired;
  logic   timed_out;
  logic   done;
  owner_t owner;

  assign in_wait = (state_q != IDLE);
  assign owner   = (state_q == D_WAIT) ? OWN_D : OWN_IF;

  arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (~in_wait),
    .enable_i (in_wait & ~mem_ack),
    .expired_o(expired)
  );

  // An ack arriving on the expiry cycle wins over the timeout.
  assign timed_out = in_wait & expired & ~mem_ack;
  assign done      = in_wait & (mem_ack | timed_out);

  assign if_ready = done & (owner == OWN_IF);
  assign d_ready  = done & (owner == OWN_D);
  assign if_err   = if_ready & timed_out;
  assign d_err    = d_ready & timed_out;
  assign if_rdata = (in_wait && owner == OWN_IF && mem_ack) ? mem_rdata : '0;
  assign d_rdata  = (in_wait && owner == OWN_D && mem_ack) ? mem_rdata : '0;

  assign stall = rst & ((if_req & ~if_ready) | (d_req & ~d_ready));

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        mem_req_d = 1'b0;
        // Data normally wins; fetch takes over once it has waited long enough.
        if (if_req && (!d_req || starve_q == MAX_G)) begin
          state_d     = IF_WAIT;
          starve_d    = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_be_d    = BE_FULL;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
        end else if (d_req) begin
          state_d     = D_WAIT;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_be_d    = d_we ? d_be : BE_FULL;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          if (!if_req) begin
            starve_d = '0;
          end else if (starve_q != MAX_G) begin
            starve_d = starve_q + 4'd1;
          end
        end
      end
      IF_WAIT, D_WAIT: begin
        if (done) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

endmodule
